pong_match_controller: RTL and testbench

Match sequencer for the Pong game. Drives the shared enable and active-low reset lines of both paddles and the ball, keeps both scores, and steps the game through idle, serve, rally, point pause and game-over. Sits between the player inputs and the paddle/ball objects. Uses the VGA frame tick as its time base.

---
 rtl/pong_match_controller.sv | 193 +++++++++++++++++++
 tb/tb_pong_match_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
// pong_match_controller
//
// Match sequencer for Pong. It steps the game through idle, serve, rally,
// point pause and game-over. It keeps both scores and drives the shared
// enable and active-low reset lines of the paddles and the ball. The VGA
// frame tick is its time base.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high
//   frame_tick     one-cycle pulse per video frame
//   start          start/restart button (level, active-high)
//   miss_left      pulse: ball left via the left edge, so the right player scores
//   miss_right     pulse: ball left via the right edge, so the left player scores
//   objects_rst_n  active-low reset to paddles and ball (effective only while enabled)
//   paddle_enable  enable for both paddles
//   ball_enable    enable for the ball
//   serve_dir      launch direction: 0 = toward left, 1 = toward right
//   score_left     left player score
//   score_right    right player score
//   state          IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
//   game_over      high in OVER
//   winner         valid in OVER: 0 = left won, 1 = right won

module pong_match_controller #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int SCORE_W      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               objects_rst_n,
    output logic               paddle_enable,
    output logic               ball_enable,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [2:0]         state,
    output logic               game_over,
    output logic               winner
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    // The frame counter runs from 0 up to the last frame of the pause, so
    // expiry is a tick that arrives while the count is already at FRAMES-1.
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]         POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_left_q, score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               start_q;
    logic               start_rise;

    // start_q resets to 1 so a button held through reset must be released
    // and pressed again before a game begins.
    assign start_rise = start & ~start_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            score_left_q  <= '0;
            score_right_q <= '0;
            serve_dir_q   <= 1'b1;
            winner_q      <= 1'b0;
            cnt_q         <= '0;
            start_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            cnt_q         <= cnt_d;
            start_q       <= start;
        end
    end

    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        cnt_d         = '0;

        paddle_enable = 1'b1;
        ball_enable   = 1'b0;
        objects_rst_n = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d       = SERVE;
                    score_left_d  = '0;
                    score_right_d = '0;
                    serve_dir_d   = 1'b1;
                end
            end

            SERVE: begin
                ball_enable = 1'b1;
                cnt_d       = cnt_q;
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            PLAY: begin
                ball_enable   = 1'b1;
                objects_rst_n = 1'b1;
                // A simultaneous miss on both sides counts as a let, so
                // neither score nor serve direction changes.
                if (miss_left && miss_right) begin
                    state_d = POINT;
                end else if (miss_left) begin
                    state_d       = POINT;
                    score_right_d = score_right_q + SCORE_W'(1);
                    serve_dir_d   = 1'b0;
                end else if (miss_right) begin
                    state_d      = POINT;
                    score_left_d = score_left_q + SCORE_W'(1);
                    serve_dir_d  = 1'b1;
                end
            end

            POINT: begin
                objects_rst_n = 1'b1;
                cnt_d         = cnt_q;
                if (frame_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        cnt_d = '0;
                        if (score_left_q == WIN) begin
                            state_d  = OVER;
                            winner_d = 1'b0;
                        end else if (score_right_q == WIN) begin
                            state_d  = OVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d = SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            OVER: begin
                paddle_enable = 1'b0;
                objects_rst_n = 1'b1;
                if (start_rise) begin
                    state_d       = SERVE;
                    score_left_d  = '0;
                    score_right_d = '0;
                    serve_dir_d   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state       = state_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign serve_dir   = serve_dir_q;
    assign winner      = winner_q;
    assign game_over   = (state_q == OVER);

endmodule

// File: tb/tb_pong_match_controller.sv
// tb_pong_match_controller
//
// Drives pong_match_controller with directed scenarios followed by random
// stimulus. After every clock edge, all outputs are compared against a
// behavioural match model kept in this bench.

module tb_pong_match_controller;

    localparam int WIN_SCORE    = 2;
    localparam int SERVE_FRAMES = 3;
    localparam int POINT_FRAMES = 2;
    localparam int SCORE_W      = 4;

    logic               clock;
    logic               reset;
    logic               frame_tick;
    logic               start;
    logic               miss_left;
    logic               miss_right;
    logic               objects_rst_n;
    logic               paddle_enable;
    logic               ball_enable;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic [2:0]         state;
    logic               game_over;
    logic               winner;

    int checks   = 0;
    int failures = 0;

    // Model of the match: phase number, scores, serve direction, winner,
    // frames still to wait in the current pause, previous button level.
    int m_phase;
    int m_left_pts;
    int m_right_pts;
    int m_dir;
    int m_win;
    int m_frames_left;
    int m_prev_start;

    pong_match_controller #(
        .WIN_SCORE   (WIN_SCORE),
        .SERVE_FRAMES(SERVE_FRAMES),
        .POINT_FRAMES(POINT_FRAMES),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .start        (start),
        .miss_left    (miss_left),
        .miss_right   (miss_right),
        .objects_rst_n(objects_rst_n),
        .paddle_enable(paddle_enable),
        .ball_enable  (ball_enable),
        .serve_dir    (serve_dir),
        .score_left   (score_left),
        .score_right  (score_right),
        .state        (state),
        .game_over    (game_over),
        .winner       (winner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic start_game();
        m_phase       = 1;
        m_left_pts    = 0;
        m_right_pts   = 0;
        m_dir         = 1;
        m_frames_left = SERVE_FRAMES;
    endtask

    task automatic model_step(input bit rst, input bit st, input bit ft, input bit ml, input bit mr);
        bit pressed;
        if (rst) begin
            m_phase       = 0;
            m_left_pts    = 0;
            m_right_pts   = 0;
            m_dir         = 1;
            m_win         = 0;
            m_frames_left = 0;
            m_prev_start  = 1;
            return;
        end
        pressed      = st && !m_prev_start;
        m_prev_start = st;
        case (m_phase)
            0, 4: if (pressed) start_game();
            1: if (ft) begin
                m_frames_left--;
                if (m_frames_left == 0) m_phase = 2;
            end
            2: if (ml || mr) begin
                if (ml && !mr) begin
                    m_right_pts++;
                    m_dir = 0;
                end else if (mr && !ml) begin
                    m_left_pts++;
                    m_dir = 1;
                end
                m_phase       = 3;
                m_frames_left = POINT_FRAMES;
            end
            3: if (ft) begin
                m_frames_left--;
                if (m_frames_left == 0) begin
                    if (m_left_pts == WIN_SCORE) begin
                        m_phase = 4;
                        m_win   = 0;
                    end else if (m_right_pts == WIN_SCORE) begin
                        m_phase = 4;
                        m_win   = 1;
                    end else begin
                        m_phase       = 1;
                        m_frames_left = SERVE_FRAMES;
                    end
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // One clock cycle: drive inputs, advance the model on the edge, and
    // compare every output shortly after the edge.
    task automatic applyStimulus(input bit rst, input bit st, input bit ft, input bit ml, input bit mr);
        reset      = rst;
        start      = st;
        frame_tick = ft;
        miss_left  = ml;
        miss_right = mr;
        @(posedge clock);
        model_step(rst, st, ft, ml, mr);
        #1;
        checkOutput("state", int'(state), m_phase);
        checkOutput("score_left", int'(score_left), m_left_pts);
        checkOutput("score_right", int'(score_right), m_right_pts);
        checkOutput("serve_dir", int'(serve_dir), m_dir);
        checkOutput("winner", int'(winner), m_win);
        checkOutput("game_over", int'(game_over), int'(m_phase == 4));
        checkOutput("paddle_enable", int'(paddle_enable), int'(m_phase != 4));
        checkOutput("ball_enable", int'(ball_enable), int'(m_phase == 1 || m_phase == 2));
        checkOutput("objects_rst_n", int'(objects_rst_n), int'(m_phase >= 2));
    endtask

    task automatic idle_cycles(input int n, input bit st);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, st, 1'b0, 1'b0, 1'b0);
    endtask

    // Spaced frame ticks, each preceded by four quiet cycles.
    task automatic spaced_ticks(input int n, input bit st);
        for (int i = 0; i < n; i++) begin
            idle_cycles(4, st);
            applyStimulus(1'b0, st, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b1;
        frame_tick = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        m_win      = 0;

        // Reset with the button held: nothing starts until it is re-pressed.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b1);
        checkOutput("held_start_idle", int'(state), 0);
        idle_cycles(1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("serve_entered", int'(state), 1);

        // Serve pause and transition into the rally.
        spaced_ticks(SERVE_FRAMES, 1'b1);
        checkOutput("play_after_serve", int'(state), 2);

        // Right player scores, then the point pause returns to serve.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("right_scored", int'(score_right), 1);
        spaced_ticks(POINT_FRAMES, 1'b0);
        spaced_ticks(SERVE_FRAMES, 1'b0);

        // A let, then a stray miss during the pause.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("let_no_score", int'(score_left), 0);
        spaced_ticks(POINT_FRAMES, 1'b0);
        spaced_ticks(SERVE_FRAMES, 1'b0);

        // Left wins 2-1.
        for (int p = 0; p < 2; p++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            spaced_ticks(POINT_FRAMES, 1'b0);
            if (p == 0) spaced_ticks(SERVE_FRAMES, 1'b0);
        end
        checkOutput("game_over_reached", int'(state), 4);
        idle_cycles(2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_winner_held", int'(winner), 0);

        // Reset in the middle of a 1-1 rally.
        spaced_ticks(SERVE_FRAMES, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        spaced_ticks(POINT_FRAMES, 1'b0);
        spaced_ticks(SERVE_FRAMES, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        spaced_ticks(POINT_FRAMES, 1'b0);
        spaced_ticks(SERVE_FRAMES, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("mid_game_reset", int'(state), 0);

        // Random play with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            bit r_rst, r_st, r_ft, r_ml, r_mr;
            r_rst = ($urandom_range(0, 499) == 0);
            r_st  = ($urandom_range(0, 9) == 0) ? ~start : start;
            r_ft  = ($urandom_range(0, 3) == 0);
            r_ml  = ($urandom_range(0, 7) == 0);
            r_mr  = ($urandom_range(0, 7) == 0);
            applyStimulus(r_rst, r_st, r_ft, r_ml, r_mr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
